seq_mul_ctrl: RTL and testbench

- Control unit that sequences the sequential signed shift-add multiplier datapath.
- Accepts an operand pair via a valid/ready handshake.
- Drives the datapath write, mux-select and clear strobes cycle by cycle.
- Presents completion to the consumer via a valid/ready handshake, and bounds every operation with an iteration counter so it always terminates.

---
 rtl/seq_mul_pkg.sv | 16 +
 rtl/seq_mul_ctrl_if.sv | 27 ++
 rtl/seq_mul_ctrl.sv | 131 +++++++++++++
 tb/tb_seq_mul_ctrl.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/seq_mul_pkg.sv
// Shared types and sizing helpers for the sequential signed shift-add multiplier.
package seq_mul_pkg;

  // Controller states: wait for operands, iterate shift/add, hold the result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } seq_mul_state_e;

  // Iteration counter must reach 2*numbits without wrapping.
  function automatic int iter_cnt_width(input int numbits);
    return $clog2(2 * numbits) + 1;
  endfunction

endpackage

// File: rtl/seq_mul_ctrl_if.sv
// Request/completion handshake between the multiplier controller and its
// requester/consumer. The master side offers operands and takes products.
interface seq_mul_ctrl_if;

  logic src_valid;
  logic src_ready;
  logic dest_valid;
  logic dest_ready;
  logic busy;

  modport master (
    output src_valid,
    output dest_ready,
    input  src_ready,
    input  dest_valid,
    input  busy
  );

  modport slave (
    input  src_valid,
    input  dest_ready,
    output src_ready,
    output dest_valid,
    output busy
  );

endinterface

// File: rtl/seq_mul_ctrl.sv
// Control unit for the sequential signed shift-add multiplier datapath.
// Loads the sign-extended operands on acceptance, then shifts the multiplier
// right and the multiplicand left each cycle, accumulating whenever the
// multiplier LSB is set. Stops when the multiplier register empties or the
// iteration cap is reached, whichever comes first, and holds the product
// until the consumer takes it.
module seq_mul_ctrl
  import seq_mul_pkg::*;
#(
  parameter int NUMBITS = 16
) (
  input  logic          clk,
  input  logic          reset,
  seq_mul_ctrl_if.slave hs,
  input  logic          numA_lsb,
  input  logic          finish,
  output logic          numA_wr,
  output logic          numB_wr,
  output logic          numA_mux_sel,
  output logic          numB_mux_sel,
  output logic          product_wr,
  output logic          product_clear
);

  localparam int CNT_W = iter_cnt_width(NUMBITS);
  localparam logic [CNT_W-1:0] ITER_CAP = CNT_W'(2 * NUMBITS);

  seq_mul_state_e   state_q, state_d;
  logic [CNT_W-1:0] iter_cnt_q, iter_cnt_d;
  logic             src_ready_q, src_ready_d;
  logic             dest_valid_q, dest_valid_d;
  logic             busy_q, busy_d;
  logic             calc_done_s;

  // Terminate when the multiplier is exhausted or the cap is hit; both
  // together still produce a single move to DONE.
  always_comb begin
    calc_done_s = finish || (iter_cnt_q == ITER_CAP);
  end

  // Next-state, counter and datapath strobe decode. Strobes are combinational
  // so the load happens on the accepting edge and accumulation follows the
  // live multiplier LSB.
  always_comb begin
    state_d       = state_q;
    iter_cnt_d    = iter_cnt_q;
    numA_wr       = 1'b0;
    numB_wr       = 1'b0;
    numA_mux_sel  = 1'b0;
    numB_mux_sel  = 1'b0;
    product_wr    = 1'b0;
    product_clear = 1'b0;
    case (state_q)
      IDLE: begin
        if (hs.src_valid) begin
          numA_wr       = 1'b1;
          numB_wr       = 1'b1;
          numA_mux_sel  = 1'b1;
          numB_mux_sel  = 1'b1;
          product_wr    = 1'b1;
          product_clear = 1'b1;
          state_d       = CALC;
          iter_cnt_d    = '0;
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        if (calc_done_s) begin
          state_d = DONE;
        end else begin
          numA_wr    = 1'b1;
          numB_wr    = 1'b1;
          product_wr = numA_lsb;
          iter_cnt_d = iter_cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (hs.dest_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d    = IDLE;
        iter_cnt_d = '0;
      end
    endcase
    // Keep the datapath quiet while reset is held, whatever the inputs do.
    if (!reset) begin
      numA_wr       = 1'b0;
      numB_wr       = 1'b0;
      numA_mux_sel  = 1'b0;
      numB_mux_sel  = 1'b0;
      product_wr    = 1'b0;
      product_clear = 1'b0;
    end else begin
      product_clear = product_clear;
    end
  end

  // Handshake status derived from the state being entered so it is registered.
  always_comb begin
    src_ready_d  = (state_d == IDLE);
    dest_valid_d = (state_d == DONE);
    busy_d       = (state_d != IDLE);
  end

  // State, iteration counter and registered handshake outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      iter_cnt_q   <= '0;
      src_ready_q  <= 1'b1;
      dest_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      iter_cnt_q   <= iter_cnt_d;
      src_ready_q  <= src_ready_d;
      dest_valid_q <= dest_valid_d;
      busy_q       <= busy_d;
    end
  end

  assign hs.src_ready  = src_ready_q;
  assign hs.dest_valid = dest_valid_q;
  assign hs.busy       = busy_q;

endmodule

// File: tb/tb_seq_mul_ctrl.sv
// Bench for seq_mul_ctrl paired with a behavioural shift-add datapath.
module tb_seq_mul_ctrl;

  localparam int NB = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  seq_mul_ctrl_if hs_if ();

  logic numA_lsb, finish;
  logic numA_wr, numB_wr, numA_mux_sel, numB_mux_sel, product_wr, product_clear;
  logic [NB-1:0] op_a = 16'd0;
  logic [NB-1:0] op_b = 16'd0;
  logic [2*NB-1:0] dp_a, dp_b, dp_prod;

  int checks = 0;
  int errors = 0;
  int pw_cnt = 0;
  bit dv_seen = 1'b0;

  seq_mul_ctrl #(.NUMBITS(NB)) dut (
    .clk(clk),
    .reset(reset),
    .hs(hs_if),
    .numA_lsb(numA_lsb),
    .finish(finish),
    .numA_wr(numA_wr),
    .numB_wr(numB_wr),
    .numA_mux_sel(numA_mux_sel),
    .numB_mux_sel(numB_mux_sel),
    .product_wr(product_wr),
    .product_clear(product_clear)
  );

  // Behavioural datapath: multiplier shifts right, multiplicand shifts left.
  assign numA_lsb = dp_a[0];
  assign finish   = (dp_a == 32'd0);
  initial forever begin
    @(posedge clk or negedge reset);
    if (!reset) begin
      dp_a <= 32'd0; dp_b <= 32'd0; dp_prod <= 32'd0;
    end else begin
      if (numA_wr) dp_a <= numA_mux_sel ? {{NB{op_a[NB-1]}}, op_a} : (dp_a >> 1);
      if (numB_wr) dp_b <= numB_mux_sel ? {{NB{op_b[NB-1]}}, op_b} : (dp_b << 1);
      if (product_wr) dp_prod <= product_clear ? 32'd0 : dp_prod + dp_b;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] sext(input logic [NB-1:0] v);
    return {{NB{v[NB-1]}}, v};
  endfunction

  // Cycles in CALC = highest set bit of the extended multiplier + 2.
  function automatic int lat_of(input logic [31:0] aext);
    int k = -1;
    for (int i = 0; i < 32; i++) if (aext[i]) k = i;
    return k + 2;
  endfunction

  // Model state: 0 idle, 1 calculating, 2 result held.
  int m_phase = 0;
  int m_idx = 0;
  int m_lat = 1;
  logic [31:0] m_aext = 32'd0;
  logic [31:0] m_prod = 32'd0;

  initial forever begin
    @(posedge clk or negedge reset);
    if (!reset) begin
      m_phase <= 0;
    end else begin
      case (m_phase)
        0: if (hs_if.src_valid) begin
          m_aext  <= sext(op_a);
          m_prod  <= sext(op_a) * sext(op_b);
          m_lat   <= lat_of(sext(op_a));
          m_idx   <= 0;
          m_phase <= 1;
        end
        1: begin
          m_idx <= m_idx + 1;
          if (m_idx + 1 == m_lat) m_phase <= 2;
        end
        default: if (hs_if.dest_ready) m_phase <= 0;
      endcase
    end
  end

  function automatic logic [5:0] exp_strobes(input int ph, input int idx, input int lat,
                                             input logic [31:0] aext, input logic sv,
                                             input logic rst);
    if (!rst) return 6'd0;
    if (ph == 0) return sv ? 6'h3F : 6'h00;
    if (ph == 1) return (idx >= lat - 1) ? 6'h00 : {4'b1100, aext[idx], 1'b0};
    return 6'h00;
  endfunction

  // Per-cycle comparison against the model, away from the active edge.
  initial forever begin
    @(negedge clk);
    chk("src_ready", {31'd0, hs_if.src_ready}, {31'd0, m_phase == 0});
    chk("dest_valid", {31'd0, hs_if.dest_valid}, {31'd0, m_phase == 2});
    chk("busy", {31'd0, hs_if.busy}, {31'd0, m_phase != 0});
    chk("strobes", {26'd0, numA_wr, numB_wr, numA_mux_sel, numB_mux_sel, product_wr, product_clear},
        {26'd0, exp_strobes(m_phase, m_idx, m_lat, m_aext, hs_if.src_valid, reset)});
    if (m_phase == 2) chk("product_model", dp_prod, m_prod);
    if (reset && hs_if.busy && !hs_if.dest_valid && product_wr) pw_cnt++;
    if (hs_if.dest_valid) dv_seen = 1'b1;
  end

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [31:0] exp_p,
                        input int exp_lat, input int exp_pw, input bit early_dr,
                        input int hold, input bit poke);
    int cyc = 0;
    chk("idle_before", {31'd0, hs_if.src_ready}, 32'd1);
    op_a = a; op_b = b; hs_if.src_valid = 1'b1; hs_if.dest_ready = early_dr;
    @(posedge clk); #1;
    hs_if.src_valid = 1'b0;
    pw_cnt = 0;
    if (poke) begin
      op_a = 16'h7777; hs_if.src_valid = 1'b1;
      @(posedge clk); #1;
      hs_if.src_valid = 1'b0; cyc = 1;
    end
    while (!hs_if.dest_valid && cyc < 100) begin
      @(posedge clk); #1; cyc++;
    end
    chk("latency", cyc, exp_lat);
    chk("product", dp_prod, exp_p);
    chk("pw_pulses", pw_cnt, exp_pw);
    for (int i = 0; i < hold; i++) begin
      hs_if.src_valid = 1'b1;
      @(posedge clk); #1;
      chk("hold_dv", {31'd0, hs_if.dest_valid}, 32'd1);
      chk("hold_prod", dp_prod, exp_p);
    end
    hs_if.dest_ready = 1'b1;
    @(posedge clk); #1;
    hs_if.src_valid = 1'b0; hs_if.dest_ready = 1'b0;
    chk("back_idle", {31'd0, hs_if.src_ready}, 32'd1);
    chk("no_bypass", {31'd0, hs_if.busy}, 32'd0);
  endtask

  initial begin
    hs_if.src_valid = 1'b0;
    hs_if.dest_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_src_ready", {31'd0, hs_if.src_ready}, 32'd1);
    chk("rst_dest_valid", {31'd0, hs_if.dest_valid}, 32'd0);
    chk("rst_busy", {31'd0, hs_if.busy}, 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    run_op(16'd3, 16'd5, 32'd15, 3, 2, 1'b1, 0, 1'b0);
    run_op(16'hFFFD, 16'd5, 32'hFFFFFFF1, 33, 31, 1'b0, 0, 1'b1);
    run_op(16'd0, 16'h1234, 32'd0, 1, 0, 1'b0, 0, 1'b0);
    run_op(16'h8000, 16'h8000, 32'h40000000, 33, 17, 1'b0, 0, 1'b0);
    run_op(16'd6, 16'd7, 32'd42, 4, 2, 1'b0, 10, 1'b0);

    // Reset in the middle of a calculation.
    dv_seen = 1'b0;
    op_a = 16'd7; op_b = 16'd9; hs_if.src_valid = 1'b1;
    @(posedge clk); #1;
    hs_if.src_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    chk("mid_busy", {31'd0, hs_if.busy}, 32'd1);
    reset = 1'b0;
    #1;
    chk("rst_mid_src_ready", {31'd0, hs_if.src_ready}, 32'd1);
    chk("rst_mid_busy", {31'd0, hs_if.busy}, 32'd0);
    chk("rst_mid_prod", dp_prod, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (10) begin @(posedge clk); #1; end
    chk("no_dv_after_reset", {31'd0, dv_seen}, 32'd0);

    run_op(16'd2, 16'hFFFC, 32'hFFFFFFF8, 3, 1, 1'b0, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
